// File: rtl/cordic_phase_gen.sv
// cordic_phase_gen: phase accumulator front end for the CORDIC sin/cos rotator.
// It accumulates W every sampling cycle and folds the top AW phase bits into
// [-pi/2, pi/2) with a flip flag. Retunes of W/A wait for a phase wrap, or for
// en to drop.
// Optional feature: define PHASE_DITHER_EN to add LFSR dither before truncation.
module cordic_phase_gen #(
    parameter int PW = 24,
    parameter int FW = 16,
    parameter int AW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [FW-1:0]        cfg_w,
    input  logic [15:0]          cfg_a,
    output logic [15:0]          A,
    output logic signed [AW-1:0] theta,
    output logic                 flip,
    output logic                 out_valid,
    output logic                 wrap
);

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] acc;
    logic [FW-1:0] w_reg, sh_w;
    logic [15:0]   sh_a;
    logic [PW:0]   acc_sum;
    logic          carry, samp, hs;
    logic          clr_acc, load_cfg, load_sh, store_sh;
    logic [AW-1:0] p, theta_nx;
    logic          p_flip;

    // Phase increment and carry-out of the accumulator
    always_comb begin
        acc_sum = {1'b0, acc} + (PW+1)'(w_reg);
        carry   = acc_sum[PW];
        samp    = (state != IDLE) && en;
        hs      = cfg_valid && cfg_ready;
    end

`ifdef PHASE_DITHER_EN
    logic [15:0]     lfsr;
    logic [PW-AW:0]  low_sum;

    // Dither the discarded low bits; the carry rounds p up by one LSB at most
    always_comb begin
        low_sum = {1'b0, acc[PW-AW-1:0]} + {1'b0, lfsr[PW-AW-1:0]};
        p       = acc[PW-1:PW-AW] + AW'(low_sum[PW-AW]);
    end

    // Fibonacci LFSR, taps 16,14,13,11, advanced once per sample
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 16'hACE1;
        else if (samp)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
`else
    // Plain truncation of the accumulator to the output angle width
    always_comb p = acc[PW-1:PW-AW];
`endif

    // Fold quadrants II/III onto IV/I by toggling the MSB; rotator negates x,y
    always_comb begin
        p_flip   = p[AW-1] ^ p[AW-2];
        theta_nx = p_flip ? (p ^ {1'b1, {(AW-1){1'b0}}}) : p;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state and the register-load controls that go with each transition
    always_comb begin
        state_nx = state;
        clr_acc  = 1'b0;
        load_cfg = 1'b0;
        load_sh  = 1'b0;
        store_sh = 1'b0;
        case (state)
            IDLE: begin
                clr_acc  = hs;
                load_cfg = hs;
                if (en)
                    state_nx = RUN;
            end
            RUN: begin
                if (!en) begin
                    // No wrap will come while stopped, so apply a late retune directly
                    load_cfg = hs;
                    state_nx = IDLE;
                end else if (hs) begin
                    store_sh = 1'b1;
                    state_nx = PEND;
                end
            end
            PEND: begin
                if (!en) begin
                    load_sh  = 1'b1;
                    state_nx = IDLE;
                end else if (carry) begin
                    load_sh  = 1'b1;
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Handshake availability
    always_comb cfg_ready = (state != PEND);

    // Accumulator, tuning registers, shadow and output sample registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            w_reg     <= '0;
            A         <= '0;
            sh_w      <= '0;
            sh_a      <= '0;
            theta     <= '0;
            flip      <= 1'b0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            if (clr_acc)
                acc <= '0;
            else if (samp)
                acc <= acc_sum[PW-1:0];
            if (load_cfg) begin
                w_reg <= cfg_w;
                A     <= cfg_a;
            end else if (load_sh) begin
                w_reg <= sh_w;
                A     <= sh_a;
            end
            if (store_sh) begin
                sh_w <= cfg_w;
                sh_a <= cfg_a;
            end
            out_valid <= samp;
            wrap      <= samp && carry;
            if (samp) begin
                theta <= theta_nx;
                flip  <= p_flip;
            end
        end
    end

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Scoreboard bench for cordic_phase_gen (PW=24, FW=16, AW=16).
// The driver runs a behavioural model and queues expected samples; the monitor
// compares every out_valid sample and records it for hand-computed spot checks.
module tb_cordic_phase_gen;

    logic               clk = 1'b0;
    logic               rst, en, cfg_valid, cfg_ready;
    logic [15:0]        cfg_w, cfg_a, A;
    logic signed [15:0] theta;
    logic               flip, out_valid, wrap;

    typedef struct {
        logic signed [15:0] theta;
        logic               flip;
        logic [15:0]        a;
        logic               wrap;
    } sample_t;

    typedef enum int {M_IDLE, M_RUN, M_PEND} mstate_t;

    sample_t exp_q[$];
    sample_t seen[$];
    int      total = 0;
    int      bad   = 0;

    mstate_t     m_st  = M_IDLE;
    logic [23:0] m_acc = '0;
    logic [15:0] m_w   = '0, m_a = '0, m_sw = '0, m_sa = '0;
    logic [15:0] m_lfsr = 16'hACE1;

    cordic_phase_gen #(.PW(24), .FW(16), .AW(16)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_w(cfg_w), .cfg_a(cfg_a), .A(A), .theta(theta), .flip(flip),
        .out_valid(out_valid), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, int act, int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", n, act, expv);
        end
    endfunction

    // Hand-computed angle; dither may legitimately round the phase up one LSB
    function automatic void chk_theta(string n, logic signed [15:0] act, logic signed [15:0] expv);
        logic signed [15:0] up;
        up = expv + 16'sd1;
`ifdef PHASE_DITHER_EN
        chk(n, int'((act == expv) || (act == up)), 1);
`else
        chk(n, int'(act), int'(expv));
`endif
    endfunction

    function automatic sample_t model_sample(logic [23:0] acc, logic [15:0] l);
        sample_t     s;
        logic [15:0] p;
        int          low;
        low = int'(acc[7:0]) + int'(l[7:0]);
`ifdef PHASE_DITHER_EN
        p = acc[23:8] + 16'(low / 256);
`else
        p = acc[23:8];
`endif
        s.flip  = p[15] ^ p[14];
        s.theta = s.flip ? (p ^ 16'h8000) : p;
        s.a     = '0;
        s.wrap  = 1'b0;
        return s;
    endfunction

    // One clock: drive inputs, advance the model, queue any expected sample
    task automatic step(input bit r, input bit e, input bit cv,
                        input logic [15:0] w, input logic [15:0] a);
        sample_t s;
        bit      hs, samp, cy;
        logic [24:0] sum;
        chk("cfg_ready", int'(cfg_ready), int'(m_st != M_PEND));
        rst = r; en = e; cfg_valid = cv; cfg_w = w; cfg_a = a;
        if (r) begin
            m_st = M_IDLE; m_acc = '0; m_w = '0; m_a = '0;
            m_sw = '0; m_sa = '0; m_lfsr = 16'hACE1;
        end else begin
            hs   = cv && (m_st != M_PEND);
            samp = (m_st != M_IDLE) && e;
            sum  = {1'b0, m_acc} + {9'd0, m_w};
            cy   = samp && sum[24];
            s    = model_sample(m_acc, m_lfsr);
            case (m_st)
                M_IDLE: begin
                    if (hs) begin m_w = w; m_a = a; m_acc = '0; end
                    if (e) m_st = M_RUN;
                end
                M_RUN: begin
                    if (!e) begin
                        if (hs) begin m_w = w; m_a = a; end
                        m_st = M_IDLE;
                    end else if (hs) begin
                        m_sw = w; m_sa = a; m_st = M_PEND;
                    end
                end
                default: begin
                    if (!e || cy) begin
                        m_w = m_sw; m_a = m_sa;
                        m_st = e ? M_RUN : M_IDLE;
                    end
                end
            endcase
            if (samp) begin
                m_acc  = sum[23:0];
                m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
                s.a    = m_a;
                s.wrap = cy;
                exp_q.push_back(s);
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            chk("rst_theta", int'(theta), 0);
            chk("rst_flip", int'(flip), 0);
            chk("rst_A", int'(A), 0);
            chk("rst_valid", int'(out_valid), 0);
            chk("rst_wrap", int'(wrap), 0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 16'd0, 16'd0);
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    // Monitor: every presented sample is popped and compared
    always @(negedge clk) begin
        sample_t act, e;
        if (out_valid === 1'b1) begin
            act.theta = theta; act.flip = flip; act.a = A; act.wrap = wrap;
            seen.push_back(act);
            if (exp_q.size() == 0) begin
                chk("unexpected_sample", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_theta", int'(act.theta), int'(e.theta));
                chk("sb_flip", int'(act.flip), int'(e.flip));
                chk("sb_A", int'(act.a), int'(e.a));
                chk("sb_wrap", int'(act.wrap), int'(e.wrap));
            end
        end else if (!rst) begin
            chk("wrap_without_sample", int'(wrap), 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; cfg_valid = 1'b1; cfg_w = 16'd4096; cfg_a = 16'd2048;
        @(posedge clk);
        #1;

        // Reset held with en and cfg_valid high, then the first edge takes the config
        for (int i = 0; i < 3; i++) step(1, 1, 1, 16'd4096, 16'd2048);
        step(0, 1, 1, 16'd4096, 16'd2048);
        seen.delete();
        run(4100);
        sync();
        chk("t1_count", seen.size(), 4100);
        chk_theta("t1_s0", seen[0].theta, 16'sd0);
        chk_theta("t1_s1", seen[1].theta, 16'sd16);
        chk_theta("t1_s2", seen[2].theta, 16'sd32);
        chk("t1_s2_A", int'(seen[2].a), 2048);
        chk_theta("t1_s1024", seen[1024].theta, -16'sd16384);
        chk("t1_s1024_flip", int'(seen[1024].flip), 1);
        chk_theta("t1_s3072", seen[3072].theta, -16'sd16384);
        chk("t1_s3072_flip", int'(seen[3072].flip), 0);
        chk("t1_s4094_wrap", int'(seen[4094].wrap), 0);
        chk("t1_s4095_wrap", int'(seen[4095].wrap), 1);
        chk_theta("t1_s4096", seen[4096].theta, 16'sd0);

        // Retune in RUN: held until the wrap, then new W and A
        seen.delete();
        step(0, 1, 1, 16'd8192, 16'd1024);
        chk("t2_ready_drop", int'(cfg_ready), 0);
        run(4099);
        sync();
        chk_theta("t2_s0", seen[0].theta, 16'sd64);
        chk_theta("t2_s1", seen[1].theta, 16'sd80);
        chk_theta("t2_s4090", seen[4090].theta, -16'sd32);
        chk("t2_s4090_wrap", int'(seen[4090].wrap), 0);
        chk_theta("t2_s4091", seen[4091].theta, -16'sd16);
        chk("t2_s4091_wrap", int'(seen[4091].wrap), 1);
        chk_theta("t2_s4092", seen[4092].theta, 16'sd0);
        chk("t2_s4092_A", int'(seen[4092].a), 1024);
        chk_theta("t2_s4093", seen[4093].theta, 16'sd32);
        chk("t2_ready_back", int'(cfg_ready), 1);

        // en dropped while pending: retune applied, acc held
        seen.delete();
        step(0, 1, 1, 16'd4096, 16'd512);
        run(9);
        step(0, 0, 0, 16'd0, 16'd0);
        chk("t3_valid_low", int'(out_valid), 0);
        step(0, 1, 0, 16'd0, 16'd0);
        run(5);
        sync();
        chk("t3_count", seen.size(), 15);
        chk_theta("t3_s9", seen[9].theta, 16'sd544);
        chk_theta("t3_s10", seen[10].theta, 16'sd576);
        chk("t3_s10_A", int'(seen[10].a), 512);
        chk_theta("t3_s11", seen[11].theta, 16'sd592);

        // Reset mid-PEND discards the shadow; W=0 gives a constant angle
        step(0, 1, 1, 16'd4096, 16'd777);
        run(3);
        step(1, 1, 0, 16'd0, 16'd0);
        seen.delete();
        step(0, 1, 0, 16'd0, 16'd0);
        run(20);
        sync();
        chk("t4_count", seen.size(), 20);
        chk_theta("t4_s0", seen[0].theta, 16'sd0);
        chk("t4_s0_A", int'(seen[0].a), 0);
        chk_theta("t4_s19", seen[19].theta, 16'sd0);
        chk("t4_s19_wrap", int'(seen[19].wrap), 0);

        // W=0 with a pending retune: waits until en drops
        seen.delete();
        step(0, 1, 1, 16'd4096, 16'd100);
        run(30);
        step(0, 0, 0, 16'd0, 16'd0);
        step(0, 1, 0, 16'd0, 16'd0);
        run(3);
        sync();
        chk("t5_count", seen.size(), 34);
        chk("t5_s30_A", int'(seen[30].a), 0);
        chk("t5_s31_A", int'(seen[31].a), 100);
        chk_theta("t5_s31", seen[31].theta, 16'sd0);
        chk_theta("t5_s32", seen[32].theta, 16'sd16);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
